hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Hazard control for a pipelined Y86-style core: tracks the destinations of
// instructions in E, EX2 and M, registers operand-forward selects for the
// datapath, and raises stall/bubble/squash controls for load-use, ret and
// branch-mispredict hazards.
// Build option: define HAZARD_CTRL_EX2_FWD_EN to forward from EX2; without it
// any E dstE dependency is resolved by a one-cycle stall instead.
module hazard_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [3:0] id_srcA,
  input  logic [3:0] id_srcB,
  input  logic [3:0] id_dstE,
  input  logic [3:0] id_dstM,
  input  logic       id_isLoad,
  input  logic       id_isRet,
  input  logic       ex_mispredict,
  output logic       apply_ex2_fwd,
  output logic [1:0] apply_mem_fwd,
  output logic       stall_f,
  output logic       stall_d,
  output logic       bubble_d,
  output logic       bubble_e,
  output logic       squash_d
);

  localparam logic [3:0] NoReg = 4'hF;

  typedef struct packed {
    logic       valid;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
    logic       is_load;
  } stage_t;

  localparam stage_t Bubble = '{valid: 1'b0, dst_e: NoReg, dst_m: NoReg, is_load: 1'b0};

  typedef enum logic [1:0] {StRun, StLoadStall, StRetWait} state_t;

  state_t     state_q;
  logic [1:0] ret_cnt_q;
  stage_t     e_q, ex2_q, m_q;
  logic [1:0] mem_fwd_q;

  logic dec_live, e_dst_e_hit, e_dst_m_hit, mem_e_hit, mem_m_hit;
  logic load_use, hazard_lu, take, ret_accept, ret_wait;

  // Register r feeds one of the decode sources; 4'hF never matches.
  function automatic logic src_hit(input logic [3:0] r, input logic [3:0] a,
                                   input logic [3:0] b);
    return (r != NoReg) && ((r == a) || (r == b));
  endfunction

  // Hazard detection and pipeline control for the current decode slot.
  always_comb begin
    ret_wait    = (state_q == StRetWait);
    // Instructions behind an outstanding ret are wrong-path; ignore decode.
    dec_live    = id_valid && !ret_wait;
    e_dst_e_hit = dec_live && e_q.valid && src_hit(e_q.dst_e, id_srcA, id_srcB);
    e_dst_m_hit = dec_live && e_q.valid && src_hit(e_q.dst_m, id_srcA, id_srcB);
    mem_e_hit   = dec_live && ex2_q.valid && src_hit(ex2_q.dst_e, id_srcA, id_srcB);
    mem_m_hit   = dec_live && ex2_q.valid && src_hit(ex2_q.dst_m, id_srcA, id_srcB);
`ifdef HAZARD_CTRL_EX2_FWD_EN
    load_use    = e_dst_m_hit && e_q.is_load;
`else
    // No EX2 path: an ALU result still in E must also wait one cycle.
    load_use    = (e_dst_m_hit && e_q.is_load) || e_dst_e_hit;
`endif
    // Mispredict outranks load-use, which outranks ret acceptance.
    hazard_lu   = load_use && !ex_mispredict;
    take        = dec_live && !ex_mispredict && !hazard_lu;
    ret_accept  = take && id_isRet;

    squash_d    = ex_mispredict;
    bubble_e    = ex_mispredict || hazard_lu;
    stall_d     = hazard_lu;
    stall_f     = !ex_mispredict && (hazard_lu || ret_wait);
    bubble_d    = !ex_mispredict && ret_wait;
  end

  // Shadow pipeline, forward selects and control FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StRun;
      ret_cnt_q <= 2'd0;
      e_q       <= Bubble;
      ex2_q     <= Bubble;
      m_q       <= Bubble;
      mem_fwd_q <= 2'b00;
    end else begin
      m_q       <= ex2_q;
      ex2_q     <= e_q;
      e_q       <= take ? '{valid: 1'b1, dst_e: id_dstE, dst_m: id_dstM, is_load: id_isLoad}
                        : Bubble;
      mem_fwd_q <= take ? {mem_e_hit, mem_m_hit} : 2'b00;

      if (ex_mispredict) begin
        state_q   <= StRun;
        ret_cnt_q <= 2'd0;
      end else if (hazard_lu) begin
        state_q <= StLoadStall;
      end else if (ret_accept) begin
        state_q   <= StRetWait;
        ret_cnt_q <= 2'd3;
      end else begin
        unique case (state_q)
          StLoadStall: state_q <= StRun;
          StRetWait: begin
            ret_cnt_q <= ret_cnt_q - 2'd1;
            if (ret_cnt_q <= 2'd1) begin
              state_q   <= StRun;
              ret_cnt_q <= 2'd0;
            end
          end
          default: state_q <= StRun;
        endcase
      end
    end
  end

`ifdef HAZARD_CTRL_EX2_FWD_EN
  logic ex2_fwd_q;

  // EX2 select: the producer now in E will sit in EX2 when decode executes.
  always_ff @(posedge clk) begin
    if (!rst_n) ex2_fwd_q <= 1'b0;
    else        ex2_fwd_q <= take && e_dst_e_hit;
  end

  assign apply_ex2_fwd = ex2_fwd_q;
`else
  assign apply_ex2_fwd = 1'b0;
`endif

  assign apply_mem_fwd = mem_fwd_q;

  // M is tracked for completeness but no select looks at it yet.
  logic unused_shadow;
  assign unused_shadow = ^{m_q, ex2_q.is_load};

endmodule
